// File: rtl/fifo_fwft.sv
// -----------------------------------------------------------------------------
// fifo_fwft
//   Single-clock FIFO built on a synchronous-read RAM. With FWFT=1 a small
//   prefetch pipeline (RAM read register + output register) presents the
//   oldest word on dout without a request; rd_en then acts as a pop. With
//   FWFT=0 rd_en is a classic read request and the word appears one edge
//   later.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   reset_n        synchronous active-low reset
//   din/wr_en      write data / write request
//   rd_en          read request (FWFT=0) or pop of the head word (FWFT=1)
//   dout           read data
//   dout_valid     dout holds a valid word
//   full/empty     count==SIZE / no word readable
//   afull/aempty   count >= afull_thresh / count <= aempty_thresh
//   afull_thresh   almost-full threshold (no range check)
//   aempty_thresh  almost-empty threshold (no range check)
//   count          occupancy 0..SIZE (accepted writes minus accepted reads)
//   overflow       sticky: a write was rejected
//   underflow      sticky: a read was rejected
//   clr_err        clears overflow/underflow
// -----------------------------------------------------------------------------
module fifo_fwft #(
    parameter int WIDTH   = 32,
    parameter int LOGSIZE = 10,
    parameter int FWFT    = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               wr_en,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   dout,
    output logic               dout_valid,
    output logic               full,
    output logic               empty,
    output logic               afull,
    output logic               aempty,
    input  logic [LOGSIZE:0]   afull_thresh,
    input  logic [LOGSIZE:0]   aempty_thresh,
    output logic [LOGSIZE:0]   count,
    output logic               overflow,
    output logic               underflow,
    input  logic               clr_err
);

    localparam int               SIZE    = 1 << LOGSIZE;
    localparam logic [LOGSIZE:0] SIZE_C  = (LOGSIZE + 1)'(SIZE);
    localparam bit               IS_FWFT = (FWFT != 0);

    logic [WIDTH-1:0]   mem [SIZE];

    logic [LOGSIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOGSIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOGSIZE:0]   count_q, count_d;
    // Words still sitting in RAM (not yet fetched into the read register).
    logic [LOGSIZE:0]   ram_cnt_q, ram_cnt_d;
    logic [WIDTH-1:0]   ram_data_q;
    logic               ram_valid_q, ram_valid_d;
    logic [WIDTH-1:0]   dout_q;
    logic               dout_valid_q, dout_valid_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;

    logic full_c;
    logic wr_acc;
    logic rd_acc;
    logic ram_rd;
    logic move;

    always_comb begin
        full_c = (count_q == SIZE_C);
        wr_acc = wr_en && !full_c;
        if (IS_FWFT) begin
            rd_acc = rd_en && dout_valid_q;
        end else begin
            rd_acc = rd_en && (count_q != '0);
        end
        // Prefetch: the read register advances into the output register
        // whenever the output slot is free or being popped this cycle.
        move = IS_FWFT && ram_valid_q && (!dout_valid_q || rd_acc);
        // Fetch from RAM whenever the read register will be free next cycle;
        // this keeps one pop per cycle sustainable with two words buffered.
        if (IS_FWFT) begin
            ram_rd = (ram_cnt_q != '0) && (!ram_valid_q || move);
        end else begin
            ram_rd = rd_acc;
        end

        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = ram_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (!wr_acc && rd_acc) begin
            count_d = count_q - 1'b1;
        end

        ram_cnt_d = ram_cnt_q;
        if (wr_acc && !ram_rd) begin
            ram_cnt_d = ram_cnt_q + 1'b1;
        end else if (!wr_acc && ram_rd) begin
            ram_cnt_d = ram_cnt_q - 1'b1;
        end

        if (IS_FWFT) begin
            ram_valid_d = ram_rd || (ram_valid_q && !move);
        end else begin
            // Without prefetch this flag marks the single cycle after a read.
            ram_valid_d = ram_rd;
        end
        dout_valid_d = move || (dout_valid_q && !rd_acc);

        // Error events win over clr_err in the same cycle.
        if (wr_en && full_c) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (rd_en && !rd_acc) begin
            udf_d = 1'b1;
        end else if (clr_err) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    // RAM array: contents survive reset; writes are blocked while in reset.
    always_ff @(posedge clk) begin
        if (reset_n && wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Registered RAM read port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_data_q <= '0;
        end else if (ram_rd) begin
            ram_data_q <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ram_cnt_q    <= '0;
            ram_valid_q  <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ram_cnt_q    <= ram_cnt_d;
            ram_valid_q  <= ram_valid_d;
            dout_valid_q <= dout_valid_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
            if (move) begin
                dout_q <= ram_data_q;
            end
        end
    end

    assign count      = count_q;
    assign full       = full_c;
    assign afull      = (count_q >= afull_thresh);
    assign aempty     = (count_q <= aempty_thresh);
    assign dout       = IS_FWFT ? dout_q : ram_data_q;
    assign dout_valid = IS_FWFT ? dout_valid_q : ram_valid_q;
    assign empty      = IS_FWFT ? !dout_valid_q : (count_q == '0);
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule

// File: tb/tb_fifo_fwft.sv
// -----------------------------------------------------------------------------
// tb_fifo_fwft
//   Two FIFOs (FWFT=1 as "a", FWFT=0 as "b"), WIDTH=8, LOGSIZE=4, share one
//   stimulus stream. A queue-based model predicts every output each cycle;
//   directed scenarios add literal expectations, then a random phase runs.
//   FWFT visibility rule used by the model: a word is shown after edge
//   max(its write edge + 2, pop edge of the previous head).
// -----------------------------------------------------------------------------
module tb_fifo_fwft;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] din;
    logic       wr_en, rd_en, clr_err;
    logic [4:0] afull_thresh, aempty_thresh;

    logic [7:0] dout_a, dout_b;
    logic       dv_a, dv_b, full_a, full_b, empty_a, empty_b;
    logic       afull_a, afull_b, aempty_a, aempty_b;
    logic [4:0] count_a, count_b;
    logic       ovf_a, ovf_b, udf_a, udf_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_fwft #(.WIDTH(8), .LOGSIZE(4), .FWFT(1)) u_a (
        .clk(clk), .reset_n(reset_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout_a), .dout_valid(dv_a), .full(full_a), .empty(empty_a),
        .afull(afull_a), .aempty(aempty_a), .afull_thresh(afull_thresh),
        .aempty_thresh(aempty_thresh), .count(count_a), .overflow(ovf_a),
        .underflow(udf_a), .clr_err(clr_err)
    );

    fifo_fwft #(.WIDTH(8), .LOGSIZE(4), .FWFT(0)) u_b (
        .clk(clk), .reset_n(reset_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout_b), .dout_valid(dv_b), .full(full_b), .empty(empty_b),
        .afull(afull_b), .aempty(aempty_b), .afull_thresh(afull_thresh),
        .aempty_thresh(aempty_thresh), .count(count_b), .overflow(ovf_b),
        .underflow(udf_b), .clr_err(clr_err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] d;
        int         e;
    } ent_t;

    ent_t       qa[$];
    logic [7:0] qb[$];
    int         cyc = 0;
    int         last_pop_a = -1000;
    bit         m_ovf_a, m_udf_a, m_ovf_b, m_udf_b;
    logic [7:0] m_dout_b = '0;
    bit         m_dv_b;

    function automatic bit vis_a(input int edge_n);
        if (qa.size() == 0) return 1'b0;
        return (qa[0].e + 2 <= edge_n) && (last_pop_a <= edge_n);
    endfunction

    initial begin
        int   e;
        bit   dv, fl, wacc, racc;
        ent_t tmp;
        forever begin
            @(posedge clk);
            e = cyc + 1;
            if (!reset_n) begin
                qa.delete();
                qb.delete();
                last_pop_a = -1000;
                m_ovf_a = 0; m_udf_a = 0; m_ovf_b = 0; m_udf_b = 0;
                m_dout_b = '0;
                m_dv_b = 0;
            end else begin
                // FWFT=1 instance
                dv   = vis_a(cyc);
                fl   = (qa.size() == 16);
                wacc = wr_en && !fl;
                racc = rd_en && dv;
                if (wr_en && fl) m_ovf_a = 1; else if (clr_err) m_ovf_a = 0;
                if (rd_en && !racc) m_udf_a = 1; else if (clr_err) m_udf_a = 0;
                if (racc) begin
                    tmp = qa.pop_front();
                    last_pop_a = e;
                end
                if (wacc) begin
                    tmp.d = din;
                    tmp.e = e;
                    qa.push_back(tmp);
                end
                // FWFT=0 instance
                fl   = (qb.size() == 16);
                wacc = wr_en && !fl;
                racc = rd_en && (qb.size() != 0);
                if (wr_en && fl) m_ovf_b = 1; else if (clr_err) m_ovf_b = 0;
                if (rd_en && !racc) m_udf_b = 1; else if (clr_err) m_udf_b = 0;
                m_dv_b = racc;
                if (racc) m_dout_b = qb.pop_front();
                if (wacc) qb.push_back(din);
            end
            cyc = e;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        bit vd;
        forever begin
            @(posedge clk);
            #2;
            vd = vis_a(cyc);
            chk("a.count", count_a, qa.size());
            chk("a.full", full_a, qa.size() == 16);
            chk("a.empty", empty_a, !vd);
            chk("a.afull", afull_a, qa.size() >= int'(afull_thresh));
            chk("a.aempty", aempty_a, qa.size() <= int'(aempty_thresh));
            chk("a.dout_valid", dv_a, vd);
            if (vd) chk("a.dout", dout_a, qa[0].d);
            chk("a.overflow", ovf_a, m_ovf_a);
            chk("a.underflow", udf_a, m_udf_a);
            chk("b.count", count_b, qb.size());
            chk("b.full", full_b, qb.size() == 16);
            chk("b.empty", empty_b, qb.size() == 0);
            chk("b.afull", afull_b, qb.size() >= int'(afull_thresh));
            chk("b.aempty", aempty_b, qb.size() <= int'(aempty_thresh));
            chk("b.dout_valid", dv_b, m_dv_b);
            chk("b.dout", dout_b, m_dout_b);
            chk("b.overflow", ovf_b, m_ovf_b);
            chk("b.underflow", udf_b, m_udf_b);
        end
    end

    // ---------------- stimulus ----------------
    // Drive inputs at the falling edge, return 2 time units after the edge
    // that sampled them.
    task automatic tick(input bit w, input logic [7:0] d, input bit r, input bit c);
        @(negedge clk);
        wr_en = w; din = d; rd_en = r; clr_err = c;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(0, 8'h00, 0, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        int wprob, rprob;
        reset_n = 1'b0; wr_en = 0; rd_en = 0; din = '0; clr_err = 0;
        afull_thresh = 5'd12; aempty_thresh = 5'd2;
        tick(0, 8'h00, 0, 0);
        tick(0, 8'h00, 0, 0);
        reset_n = 1'b1;
        chk("rst.count", count_a, 0);
        chk("rst.empty", empty_a, 1);
        chk("rst.full", full_a, 0);
        chk("rst.aempty", aempty_a, 1);
        chk("rst.afull", afull_a, 0);
        chk("rst.dout", dout_a, 0);

        // First-word fall-through latency
        tick(1, 8'hA5, 0, 0);
        chk("fw.dv_k", dv_a, 0);
        chk("fw.count", count_a, 1);
        chk("fw.b_empty", empty_b, 0);
        tick(0, 8'h00, 0, 0);
        chk("fw.dv_k1", dv_a, 0);
        tick(0, 8'h00, 0, 0);
        chk("fw.dv_k2", dv_a, 1);
        chk("fw.dout", dout_a, 8'hA5);
        tick(0, 8'h00, 1, 0);
        chk("fw.pop_empty", empty_a, 1);
        chk("fw.pop_count", count_a, 0);
        chk("fw.b_dout", dout_b, 8'hA5);

        // Standard mode: read with write on empty
        tick(1, 8'h11, 1, 0);
        chk("std.underflow", udf_b, 1);
        chk("std.count", count_b, 1);
        chk("std.dv_early", dv_b, 0);
        tick(0, 8'h00, 1, 0);
        chk("std.dv", dv_b, 1);
        chk("std.dout", dout_b, 8'h11);
        tick(0, 8'h00, 0, 1);
        chk("std.clr", udf_b, 0);
        chk("std.hold", dout_b, 8'h11);
        do_reset();

        // Fill to full with almost-flags, overflow, clear
        for (int i = 1; i <= 16; i++) begin
            tick(1, 8'(i), 0, 0);
            chk("fill.count", count_a, i);
            chk("fill.aempty", aempty_a, i <= 2);
            chk("fill.afull", afull_a, i >= 12);
            chk("fill.full", full_b, i == 16);
        end
        tick(1, 8'h99, 0, 0);
        chk("ovf.set", ovf_a, 1);
        chk("ovf.count", count_a, 16);
        tick(0, 8'h00, 0, 1);
        chk("ovf.clr", ovf_a, 0);
        do_reset();

        // Reset at count=7 while popping
        tick(0, 8'h00, 1, 0);
        chk("rp.udf", udf_a, 1);
        for (int i = 0; i < 7; i++) tick(1, 8'(8'h30 + i), 0, 0);
        tick(0, 8'h00, 0, 0);
        tick(0, 8'h00, 0, 0);
        chk("rp.count7", count_a, 7);
        reset_n = 1'b0;
        tick(1, 8'hEE, 1, 0);
        reset_n = 1'b1;
        chk("rp.count", count_a, 0);
        chk("rp.dv", dv_a, 0);
        chk("rp.dout", dout_a, 0);
        chk("rp.udf_clr", udf_a, 0);
        chk("rp.b_dout", dout_b, 0);
        tick(1, 8'h5C, 0, 0);
        tick(0, 8'h00, 0, 0);
        tick(0, 8'h00, 0, 0);
        chk("rp.first_a", dout_a, 8'h5C);
        tick(0, 8'h00, 1, 0);
        chk("rp.first_b", dout_b, 8'h5C);
        chk("rp.a_empty", empty_a, 1);
        do_reset();

        // Streaming 40 words through the pointer wrap
        for (int t = 0; t <= 42; t++) begin
            tick(t < 40, 8'(t), t >= 3, 0);
            if (t >= 2 && t <= 41) begin
                chk("str.dv", dv_a, 1);
                chk("str.dout", dout_a, t - 2);
            end
        end
        chk("str.empty", empty_a, 1);
        chk("str.udf", udf_a, 0);
        chk("str.b_udf", udf_b, 0);

        // Random traffic
        wprob = 50; rprob = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                wprob = $urandom_range(10, 90);
                rprob = $urandom_range(10, 90);
            end
            if (n % 50 == 0) begin
                afull_thresh  = 5'($urandom_range(0, 31));
                aempty_thresh = 5'($urandom_range(0, 31));
            end
            reset_n = ($urandom_range(0, 249) != 0);
            tick($urandom_range(0, 99) < wprob, 8'($urandom), $urandom_range(0, 99) < rprob,
                 $urandom_range(0, 15) == 0);
        end
        reset_n = 1'b1;
        tick(0, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
